mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit; the single clock, with all flops on its rising edge.
REQ-002 SHALL have port proc_rst, input, 1 bit; reset, asynchronous, active-high.
REQ-003 SHALL have port req_valid, input, 1 bit; access request.
REQ-004 SHALL have port req_ready, output, 1 bit; controller idle, request accepted when req_valid & req_ready.
REQ-005 SHALL have port req_write, input, 1 bit; 1 = store burst, 0 = load burst.
REQ-006 SHALL have port req_addr, input, 5 bits; first word address.
REQ-007 SHALL have port req_count, input, 3 bits; burst length minus one (1..8 words).
REQ-008 SHALL have port wr_data, input, 16 bits; next store word from source.
REQ-009 SHALL have port wr_pop, output, 1 bit; wr_data sampled this cycle, source advances.
REQ-010 SHALL have port rd_data, output, 16 bits; loaded word.
REQ-011 SHALL have port rd_valid, output, 1 bit; rd_data valid this cycle.
REQ-012 SHALL have port rd_idx, output, 3 bits; beat index of rd_data.
REQ-013 SHALL have port done, output, 1 bit; one-cycle burst-complete pulse.
REQ-014 SHALL have port mem_addr, output, 5 bits; memory address.
REQ-015 SHALL have port mem_wdata, output, 16 bits; memory write data.
REQ-016 SHALL have port mem_write_n, output, 1 bit; active-low write strobe.
REQ-017 SHALL have port mem_read_n, output, 1 bit; active-low read strobe.
REQ-018 SHALL have port mem_rdata, input, 16 bits; memory registered read data, updated on falling clk.

Function
REQ-019 SHALL implement FSM states IDLE, READ, WRITE; req_ready = (state == IDLE).
REQ-020 SHALL, on acceptance in cycle 0, enter READ/WRITE at the next edge, with mem_addr=req_addr, beat=0, and the strobe low from cycle 1.
REQ-021 SHALL keep the strobe low for exactly N=req_count+1 consecutive cycles (1..N), with mem_addr incremented by one per cycle.
REQ-022 SHALL wrap mem_addr modulo 32 (31 -> 0) within a burst.
REQ-023 SHALL never drive mem_write_n and mem_read_n low simultaneously; the inactive strobe stays 1.
REQ-024 SHALL, in READ, register mem_rdata into rd_data at the edge after each strobe cycle; rd_valid is high in cycles 2..N+1 with rd_idx 0..N-1.
REQ-025 SHALL, in WRITE, register wr_data into mem_wdata at the acceptance edge and at each non-final beat edge; wr_pop is high in cycle 0 and cycles 1..N-1 (N pops total).
REQ-026 SHALL return to IDLE after the last beat, pulse done in cycle N+1, and raise req_ready in cycle N+1; back-to-back acceptance is allowed there.
REQ-027 SHALL ignore req_valid and all req_* inputs while not IDLE; burst parameters are latched only at acceptance.
REQ-028 SHALL hold rd_data and mem_wdata stable when not updated.

Reset
REQ-029 SHALL, on proc_rst=1 (asynchronous, any state, including mid-burst), force state=IDLE, mem_write_n=1, mem_read_n=1, mem_addr=0, mem_wdata=0, rd_data=0, rd_valid=0, rd_idx=0, done=0, wr_pop=0, req_ready=1.
REQ-030 SHALL issue no done pulse and no further strobe for a burst aborted by reset.

Structure
REQ-031 SHALL place ADDR_W=5, DATA_W=16, CNT_W=3 and the FSM state type in shared package mem_pkg.
REQ-032 SHALL be a single module with no sub-module; the beat counter and address incrementer are inline.

Verification
REQ-033 SHALL cover a single read: preload mem[3]=16'h3369, request read addr 3, count 0 -> mem_read_n low in cycle 1 only, rd_valid in cycle 2 with rd_data=16'h3369 and rd_idx 0, done in cycle 2.
REQ-034 SHALL cover a write burst: addr 5, count 3, source words A1..A4 -> wr_pop in cycles 0..3, mem[5..8]=A1..A4, mem_write_n low in cycles 1..4, done in cycle 5.
REQ-035 SHALL cover address wrap: read addr 30, count 3 -> mem_addr 30, 31, 0, 1; rd_idx 0..3 match the preloaded words.
REQ-036 SHALL cover a request while busy: req_valid held high during an 8-beat read with different parameters -> ignored; second burst starts in the cycle after done.
REQ-037 SHALL cover reset mid-burst: proc_rst asserted in beat 2 of a 4-beat write -> both strobes 1 immediately; mem[addr+2..addr+3] unchanged; no done pulse; req_ready=1.
REQ-038 SHALL cover strobe exclusivity: a random mix of 200 bursts -> assertion that mem_write_n|mem_read_n is always 1, and that strobe-low cycle count equals the total of N.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared widths and FSM state type for the burst memory access controller.
package mem_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

endpackage

// File: rtl/mem_access_ctrl.sv
// Burst memory access controller: accepts one load/store burst of 1..8 words
// and drives an active-low strobed memory, one word per cycle, address wrapping.
module mem_access_ctrl
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              proc_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [CNT_W-1:0]  req_count,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_idx,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write_n,
    output logic              mem_read_n,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0]  rd_idx_q, rd_idx_d;
    logic              done_q, done_d;

    logic accept;
    logic last_beat;

    assign accept    = req_valid && (state_q == ST_IDLE);
    assign last_beat = (beat_q == count_q);

    // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
    always_ff @(posedge clk or posedge proc_rst) begin
        if (proc_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:            if (req_valid) state_d = req_write ? ST_WRITE : ST_READ;
            ST_READ, ST_WRITE:  if (last_beat) state_d = ST_IDLE;
            default:            state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge proc_rst) begin
        if (proc_rst) begin
            mem_addr_q  <= '0;
            beat_q      <= '0;
            count_q     <= '0;
            mem_wdata_q <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_idx_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            beat_q      <= beat_d;
            count_q     <= count_d;
            mem_wdata_q <= mem_wdata_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_idx_q    <= rd_idx_d;
            done_q      <= done_d;
        end
    end

    // NOTE: every signal gets a default first so no latch is inferred.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        beat_d      = beat_q;
        count_d     = count_q;
        mem_wdata_d = mem_wdata_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        rd_idx_d    = rd_idx_q;
        done_d      = 1'b0;
        if (accept) begin
            mem_addr_d = req_addr;
            beat_d     = '0;
            count_d    = req_count;
            if (req_write) mem_wdata_d = wr_data;
        end else if (state_q != ST_IDLE) begin
            // Address wraps naturally at the ADDR_W boundary.
            mem_addr_d = mem_addr_q + ADDR_W'(1);
            beat_d     = beat_q + CNT_W'(1);
            done_d     = last_beat;
            if (state_q == ST_READ) begin
                rd_data_d  = mem_rdata;
                rd_valid_d = 1'b1;
                rd_idx_d   = beat_q;
            end else if (!last_beat) begin
                // The final word was already staged on the previous beat.
                mem_wdata_d = wr_data;
            end
        end
    end

    always_comb begin
        req_ready   = (state_q == ST_IDLE);
        mem_read_n  = (state_q != ST_READ);
        mem_write_n = (state_q != ST_WRITE);
        wr_pop      = 1'b0;
        if (!proc_rst) begin
            if (state_q == ST_IDLE)       wr_pop = req_valid && req_write;
            else if (state_q == ST_WRITE) wr_pop = !last_beat;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_idx    = rd_idx_q;
    assign done      = done_q;

endmodule
